// File: rtl/imm_extend_pipe_pkg.sv
// Shared encodings for the pipelined immediate extender: extension modes and
// the skid-buffer occupancy states.
package imm_extend_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_SEXT     = 2'b00,
        MODE_ZEXT     = 2'b01,
        MODE_SEXT_SHL = 2'b10,
        MODE_RSVD     = 2'b11
    } ImmMode_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b10
    } PipeState_t;

endpackage

// File: rtl/imm_extend_core.sv
// Purely combinational IN_W -> OUT_W immediate extender with selectable mode.
// Reserved mode yields zero data and raises err.
module imm_extend_core
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int OUT_W = 8,
    parameter int SHAMT = 1
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] data,
    output logic             err
);

    // Bits above the immediate; 64-bit math keeps IN_W == 32 from overflowing.
    localparam logic [OUT_W-1:0] UPPER_MASK = ~OUT_W'((64'd1 << IN_W) - 64'd1);

    logic [OUT_W-1:0] zextVal;
    logic [OUT_W-1:0] sextVal;

    always_comb begin
        zextVal = OUT_W'(imm);
        sextVal = zextVal | (imm[IN_W-1] ? UPPER_MASK : '0);
        data    = '0;
        err     = 1'b0;
        case (mode)
            MODE_SEXT:     data = sextVal;
            MODE_ZEXT:     data = zextVal;
            MODE_SEXT_SHL: data = sextVal << SHAMT;
            default:       err  = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender with valid/ready on both sides, a 2-entry
// (main + skid) output buffer, registered in_ready and a transfer counter.
module imm_extend_pipe
    import imm_extend_pipe_pkg::*;
#(
    parameter int IN_W  = 2,
    parameter int OUT_W = 8,
    parameter int SHAMT = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_imm,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] xfer_cnt
);

    if (IN_W < 1 || IN_W > OUT_W) begin : gBadInW
        $error("imm_extend_pipe: IN_W must be in 1..OUT_W");
    end
    if (SHAMT < 0 || SHAMT >= OUT_W) begin : gBadShamt
        $error("imm_extend_pipe: SHAMT must be in 0..OUT_W-1");
    end
    if (OUT_W > 32) begin : gBadOutW
        $error("imm_extend_pipe: OUT_W must not exceed 32");
    end

    PipeState_t       state;
    PipeState_t       nextState;
    logic [OUT_W-1:0] extData;
    logic             extErr;
    logic [OUT_W-1:0] skidData;
    logic             skidErr;
    logic             accept;
    logic             drain;
    logic             loadMainIn;
    logic             loadMainSkid;
    logic             loadSkid;

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .SHAMT (SHAMT)
    ) uCore (
        .imm  (in_imm),
        .mode (in_mode),
        .data (extData),
        .err  (extErr)
    );

    assign accept    = in_valid & in_ready;
    assign out_valid = (state != ST_EMPTY);
    assign drain     = out_valid & out_ready;

    always_comb begin
        nextState    = state;
        loadMainIn   = 1'b0;
        loadMainSkid = 1'b0;
        loadSkid     = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (accept) begin
                    nextState  = ST_ONE;
                    loadMainIn = 1'b1;
                end
            end
            ST_ONE: begin
                if (accept && drain) begin
                    loadMainIn = 1'b1;
                end else if (accept) begin
                    nextState = ST_FULL;
                    loadSkid  = 1'b1;
                end else if (drain) begin
                    nextState = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    nextState    = ST_ONE;
                    loadMainSkid = 1'b1;
                end
            end
            default: nextState = ST_EMPTY;
        endcase
    end

    // in_ready is registered from the next state so it never depends on out_ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            in_ready <= 1'b1;
        end else begin
            state    <= nextState;
            in_ready <= (nextState != ST_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_err  <= 1'b0;
            skidData <= '0;
            skidErr  <= 1'b0;
        end else begin
            if (loadMainIn) begin
                out_data <= extData;
                out_err  <= extErr;
            end else if (loadMainSkid) begin
                out_data <= skidData;
                out_err  <= skidErr;
            end
            if (loadSkid) begin
                skidData <= extData;
                skidErr  <= extErr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (drain) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench: two instances (default 2->8 with a 2-bit counter, and
// 4->16) checked every cycle against a queue-based arithmetic model.
module tb_imm_extend_pipe;

    localparam int AIN  = 2;
    localparam int AOUT = 8;
    localparam int ASH  = 1;
    localparam int ACNT = 2;
    localparam int BIN  = 4;
    localparam int BOUT = 16;
    localparam int BSH  = 3;
    localparam int BCNT = 8;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } Exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    logic            aInValid = 1'b0;
    logic            aInReady;
    logic [AIN-1:0]  aInImm   = '0;
    logic [1:0]      aInMode  = 2'b00;
    logic            aOutValid;
    logic            aOutReady = 1'b1;
    logic [AOUT-1:0] aOutData;
    logic            aOutErr;
    logic [ACNT-1:0] aXferCnt;

    logic            bInValid = 1'b0;
    logic            bInReady;
    logic [BIN-1:0]  bInImm   = '0;
    logic [1:0]      bInMode  = 2'b00;
    logic            bOutValid;
    logic            bOutReady = 1'b1;
    logic [BOUT-1:0] bOutData;
    logic            bOutErr;
    logic [BCNT-1:0] bXferCnt;

    int   compared   = 0;
    int   mismatched = 0;
    Exp_t aQ[$];
    Exp_t bQ[$];
    int   aCnt    = 0;
    int   bCnt    = 0;
    int   bPushes = 0;

    always #5 clk = ~clk;

    imm_extend_pipe #(.IN_W(AIN), .OUT_W(AOUT), .SHAMT(ASH), .CNT_W(ACNT)) dutA (
        .clk(clk), .rst_n(rst_n),
        .in_valid(aInValid), .in_ready(aInReady), .in_imm(aInImm), .in_mode(aInMode),
        .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
        .out_err(aOutErr), .xfer_cnt(aXferCnt)
    );

    imm_extend_pipe #(.IN_W(BIN), .OUT_W(BOUT), .SHAMT(BSH), .CNT_W(BCNT)) dutB (
        .clk(clk), .rst_n(rst_n),
        .in_valid(bInValid), .in_ready(bInReady), .in_imm(bInImm), .in_mode(bInMode),
        .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
        .out_err(bOutErr), .xfer_cnt(bXferCnt)
    );

    // Interpret the immediate as a number, scale it, and reduce modulo 2^outW.
    function automatic logic [31:0] modelExt(input int inW, input int outW, input int shamt,
                                             input logic [31:0] imm, input logic [1:0] mode,
                                             output logic err);
        longint v;
        v   = longint'(imm) & ((longint'(1) << inW) - 1);
        err = 1'b0;
        case (mode)
            2'b00: if (v >= (longint'(1) << (inW - 1))) v = v - (longint'(1) << inW);
            2'b01: v = v;
            2'b10: begin
                if (v >= (longint'(1) << (inW - 1))) v = v - (longint'(1) << inW);
                v = v * (longint'(1) << shamt);
            end
            default: begin
                v   = 0;
                err = 1'b1;
            end
        endcase
        return 32'(v & ((longint'(1) << outW) - 1));
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulusA(input logic valid, input logic [AIN-1:0] imm,
                                  input logic [1:0] mode);
        aInValid = valid;
        aInImm   = imm;
        aInMode  = mode;
    endtask

    task automatic applyStimulusB(input logic valid, input logic [BIN-1:0] imm,
                                  input logic [1:0] mode);
        bInValid = valid;
        bInImm   = imm;
        bInMode  = mode;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        Exp_t e;
        if (!rst_n) begin
            aQ.delete();
            aCnt = 0;
        end else begin
            checkOutput("A.out_valid", 32'(aOutValid), 32'(aQ.size() > 0));
            checkOutput("A.in_ready", 32'(aInReady), 32'(aQ.size() < 2));
            checkOutput("A.xfer_cnt", 32'(aXferCnt), 32'(aCnt % (1 << ACNT)));
            if (aOutValid && aQ.size() > 0) begin
                checkOutput("A.out_data", 32'(aOutData), aQ[0].data);
                checkOutput("A.out_err", 32'(aOutErr), 32'(aQ[0].err));
                if (aOutReady) begin
                    void'(aQ.pop_front());
                    aCnt++;
                end
            end
            if (aInValid && aInReady) begin
                e.data = modelExt(AIN, AOUT, ASH, 32'(aInImm), aInMode, e.err);
                aQ.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        Exp_t e;
        if (!rst_n) begin
            bQ.delete();
            bCnt    = 0;
            bPushes = 0;
        end else begin
            checkOutput("B.out_valid", 32'(bOutValid), 32'(bQ.size() > 0));
            checkOutput("B.in_ready", 32'(bInReady), 32'(bQ.size() < 2));
            checkOutput("B.xfer_cnt", 32'(bXferCnt), 32'(bCnt % (1 << BCNT)));
            if (bOutValid && bQ.size() > 0) begin
                checkOutput("B.out_data", 32'(bOutData), bQ[0].data);
                checkOutput("B.out_err", 32'(bOutErr), 32'(bQ[0].err));
                if (bOutReady) begin
                    void'(bQ.pop_front());
                    bCnt++;
                end
            end
            if (bInValid && bInReady) begin
                e.data = modelExt(BIN, BOUT, BSH, 32'(bInImm), bInMode, e.err);
                bQ.push_back(e);
                bPushes++;
            end
        end
    end

    initial begin
        logic e;

        // Hand-computed anchors for the model.
        checkOutput("model SEXT 10", modelExt(2, 8, 1, 32'h2, 2'b00, e), 32'hFE);
        checkOutput("model SEXT 11", modelExt(2, 8, 1, 32'h3, 2'b00, e), 32'hFF);
        checkOutput("model SHL 11", modelExt(2, 8, 1, 32'h3, 2'b10, e), 32'hFE);
        checkOutput("model ZEXT 1010", modelExt(4, 16, 3, 32'hA, 2'b01, e), 32'h000A);
        checkOutput("model SHL 1001", modelExt(4, 16, 3, 32'h9, 2'b10, e), 32'hFFC8);
        checkOutput("model RSVD data", modelExt(4, 16, 3, 32'h5, 2'b11, e), 32'h0);
        checkOutput("model RSVD err", 32'(e), 32'h1);

        repeat (3) nextCycle();
        checkOutput("reset out_valid", 32'(aOutValid), 32'h0);
        checkOutput("reset in_ready", 32'(aInReady), 32'h1);
        checkOutput("reset xfer_cnt", 32'(aXferCnt), 32'h0);
        checkOutput("reset out_data", 32'(aOutData), 32'h0);
        checkOutput("reset out_err", 32'(aOutErr), 32'h0);
        rst_n = 1'b1;

        // Basic modes, reserved mid-stream and 2-bit counter wrap on instance A.
        nextCycle();
        applyStimulusA(1'b1, 2'b10, 2'b00);
        nextCycle();
        checkOutput("t1 SEXT data", 32'(aOutData), 32'hFE);
        checkOutput("t1 SEXT err", 32'(aOutErr), 32'h0);
        applyStimulusA(1'b1, 2'b01, 2'b01);
        nextCycle();
        checkOutput("t1 ZEXT data", 32'(aOutData), 32'h01);
        checkOutput("t1 cnt 1", 32'(aXferCnt), 32'h1);
        applyStimulusA(1'b1, 2'b11, 2'b10);
        nextCycle();
        checkOutput("t1 SHL data", 32'(aOutData), 32'hFE);
        checkOutput("t1 cnt 2", 32'(aXferCnt), 32'h2);
        applyStimulusA(1'b1, 2'b10, 2'b11);
        nextCycle();
        checkOutput("t1 RSVD data", 32'(aOutData), 32'h00);
        checkOutput("t1 RSVD err", 32'(aOutErr), 32'h1);
        checkOutput("t1 cnt 3", 32'(aXferCnt), 32'h3);
        applyStimulusA(1'b1, 2'b11, 2'b00);
        nextCycle();
        checkOutput("t1 after RSVD data", 32'(aOutData), 32'hFF);
        checkOutput("t1 after RSVD err", 32'(aOutErr), 32'h0);
        checkOutput("t1 cnt wrap 0", 32'(aXferCnt), 32'h0);
        applyStimulusA(1'b0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("t1 cnt 1 again", 32'(aXferCnt), 32'h1);
        checkOutput("t1 idle valid", 32'(aOutValid), 32'h0);

        // Backpressure: third item held off until the skid entry drains.
        aOutReady = 1'b0;
        applyStimulusA(1'b1, 2'b01, 2'b00);
        nextCycle();
        checkOutput("bp ready after 1st", 32'(aInReady), 32'h1);
        applyStimulusA(1'b1, 2'b10, 2'b01);
        nextCycle();
        checkOutput("bp ready after 2nd", 32'(aInReady), 32'h0);
        applyStimulusA(1'b1, 2'b11, 2'b01);
        nextCycle();
        checkOutput("bp held ready", 32'(aInReady), 32'h0);
        checkOutput("bp held data", 32'(aOutData), 32'h01);
        aOutReady = 1'b1;
        nextCycle();
        checkOutput("bp drain 2nd", 32'(aOutData), 32'h02);
        checkOutput("bp ready back", 32'(aInReady), 32'h1);
        nextCycle();
        checkOutput("bp drain 3rd", 32'(aOutData), 32'h03);
        applyStimulusA(1'b0, 2'b00, 2'b00);
        nextCycle();
        checkOutput("bp empty", 32'(aOutValid), 32'h0);

        // Streaming on instance B: one accept per cycle for 20 cycles.
        for (int i = 0; i < 20; i++) begin
            applyStimulusB(1'b1, BIN'(i), (i >= 16) ? 2'b10 : 2'b00);
            nextCycle();
        end
        applyStimulusB(1'b0, '0, 2'b00);
        checkOutput("stream pushes", 32'(bPushes), 32'd20);
        nextCycle();
        nextCycle();
        checkOutput("stream xfer_cnt", 32'(bXferCnt), 32'd20);

        // Asynchronous reset while instance A sits full.
        aOutReady = 1'b0;
        applyStimulusA(1'b1, 2'b10, 2'b00);
        nextCycle();
        nextCycle();
        applyStimulusA(1'b0, 2'b00, 2'b00);
        checkOutput("rst pre full", 32'(aInReady), 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async rst out_valid", 32'(aOutValid), 32'h0);
        checkOutput("async rst in_ready", 32'(aInReady), 32'h1);
        checkOutput("async rst xfer_cnt", 32'(aXferCnt), 32'h0);
        checkOutput("async rst out_data", 32'(aOutData), 32'h0);
        nextCycle();
        rst_n = 1'b1;
        aOutReady = 1'b1;
        repeat (3) begin
            nextCycle();
            checkOutput("post rst no stale", 32'(aOutValid), 32'h0);
        end
        checkOutput("A queue drained", 32'(aQ.size()), 32'h0);
        checkOutput("B queue drained", 32'(bQ.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
